frame_byte_streamer: RTL

- Parametrised successor to the single-frame capture/UART path.
- Packs a stream of camera pixels into N-pixel words and buffers them in an internal FIFO.
- Drains the FIFO as a byte stream over a valid/ready handshake to the SPART transmit driver.
- Adds generic pixel/word geometry, an optional per-frame sync header, continuous or single-shot mode, overflow detection and a frame-done pulse, all in one clock domain.

---
 rtl/frame_byte_streamer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_byte_streamer.sv
// frame_byte_streamer
//   Packs camera pixels into PIX_PER_WORD-pixel words, buffers them in a small FIFO and
//   drains each word as a little-endian byte stream over a valid/ready handshake.
//   An optional sync byte precedes every frame. Single-shot or continuous capture.
//
// Ports
//   CLK, RST       clock, synchronous active-high reset
//   iDATA          pixel data (PIX_W bits), qualified by iDATA_VAL
//   arm            start-capture pulse (only honoured while fully idle)
//   continuous     re-arm automatically at frame end (sampled at frame end)
//   o_byte         byte to transmit driver, qualified by o_byte_valid
//   i_byte_ready   driver accepts the byte this cycle
//   busy           capture or transmit in progress
//   frame_done     one-cycle pulse after the last byte of a frame transfers
//   overflow       sticky: a completed word was dropped because the FIFO was full
//   fifo_empty     registered FIFO-empty flag
module frame_byte_streamer #(
    parameter int unsigned PIX_W        = 12,
    parameter int unsigned PIX_PER_WORD = 3,
    parameter int unsigned FRAME_WORDS  = 102400,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter bit          HDR_EN       = 1'b1,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [PIX_W-1:0] iDATA,
    input  logic             iDATA_VAL,
    input  logic             arm,
    input  logic             continuous,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow,
    output logic             fifo_empty
);

    localparam int unsigned W      = PIX_W * PIX_PER_WORD;
    localparam int unsigned NBYTES = (W + 7) / 8;
    localparam int unsigned SW     = NBYTES * 8;
    localparam int unsigned PIW    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int unsigned CW     = $clog2(FRAME_WORDS + 1);
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW   = AW + 1;
    localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [PIW-1:0]  LAST_PIX  = PIW'(PIX_PER_WORD - 1);
    localparam logic [CW-1:0]   LAST_WORD = CW'(FRAME_WORDS - 1);
    localparam logic [BW-1:0]   LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {CIdle, CCapt, CWait} cap_state_e;
    typedef enum logic [1:0] {TIdle, THdr, TWaitW, TByte} tx_state_e;

    cap_state_e cap_state;
    tx_state_e  tx_state;

    // Capture side
    logic [PIX_W-1:0] pack [PIX_PER_WORD];
    logic [PIW-1:0]   pix_idx;
    logic [CW-1:0]    word_cnt;   // words completed, dropped or not
    logic [CW-1:0]    enq_cnt;    // words actually written to the FIFO
    logic [W-1:0]     word_in;

    // FIFO
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_next;
    logic             last_pix;
    logic             push;
    logic             pop;

    // Transmit side
    logic [SW-1:0]    head_ext;
    logic [SW-1:0]    shift;      // bytes still to send after the one on o_byte
    logic [BW-1:0]    byte_idx;
    logic [CW-1:0]    tx_word_cnt;
    logic             restart;
    logic             frame_end;

    // Completed word: buffered pixels plus the pixel arriving this cycle in the top slot.
    always_comb begin
        word_in = '0;
        for (int unsigned i = 0; i + 1 < PIX_PER_WORD; i++) begin
            word_in[i*PIX_W +: PIX_W] = pack[i];
        end
        word_in[(PIX_PER_WORD-1)*PIX_W +: PIX_W] = iDATA;
    end

    assign last_pix = (cap_state == CCapt) && iDATA_VAL && (pix_idx == LAST_PIX);
    assign pop      = (tx_state == TWaitW) && (count != '0);
    // A same-cycle pop frees a slot, so a write into a full FIFO still succeeds.
    assign push     = last_pix && ((count != FULL_CNT) || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_next;
            fifo_empty <= (count_next == '0);
        end
    end

    assign head_ext = SW'(mem[rd_ptr]);

    // Frame ends on the last byte of the last enqueued word, once capture has stopped.
    assign frame_end = (tx_state == TByte) && i_byte_ready && (byte_idx == LAST_BYTE) &&
                       (tx_word_cnt + CW'(1) == enq_cnt) && (cap_state == CWait);

    // Capture FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_state <= CIdle;
            pix_idx   <= '0;
            word_cnt  <= '0;
            enq_cnt   <= '0;
            overflow  <= 1'b0;
            for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
                pack[i] <= '0;
            end
        end else begin
            case (cap_state)
                CIdle: begin
                    if (arm) begin
                        cap_state <= CCapt;
                        pix_idx   <= '0;
                        word_cnt  <= '0;
                        enq_cnt   <= '0;
                    end
                end
                CCapt: begin
                    if (iDATA_VAL) begin
                        if (pix_idx == LAST_PIX) begin
                            pix_idx  <= '0;
                            word_cnt <= word_cnt + CW'(1);
                            if (push) begin
                                enq_cnt <= enq_cnt + CW'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                            if (word_cnt == LAST_WORD) begin
                                cap_state <= CWait;
                            end
                        end else begin
                            pack[pix_idx] <= iDATA;
                            pix_idx       <= pix_idx + PIW'(1);
                        end
                    end
                end
                CWait: begin
                    if (frame_end) begin
                        if (continuous) begin
                            cap_state <= CCapt;
                            pix_idx   <= '0;
                            word_cnt  <= '0;
                            enq_cnt   <= '0;
                        end else begin
                            cap_state <= CIdle;
                        end
                    end
                end
                default: cap_state <= CIdle;
            endcase
        end
    end

    // Transmit FSM; o_byte / o_byte_valid / frame_done are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state     <= TIdle;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            frame_done   <= 1'b0;
            restart      <= 1'b0;
            shift        <= '0;
            byte_idx     <= '0;
            tx_word_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (tx_state)
                TIdle: begin
                    if (restart || (arm && (cap_state == CIdle))) begin
                        restart     <= 1'b0;
                        tx_word_cnt <= '0;
                        if (HDR_EN) begin
                            tx_state     <= THdr;
                            o_byte       <= SYNC_BYTE;
                            o_byte_valid <= 1'b1;
                        end else begin
                            tx_state <= TWaitW;
                        end
                    end
                end
                THdr: begin
                    if (i_byte_ready) begin
                        tx_state     <= TWaitW;
                        o_byte       <= '0;
                        o_byte_valid <= 1'b0;
                    end
                end
                TWaitW: begin
                    if (count != '0) begin
                        tx_state     <= TByte;
                        o_byte       <= head_ext[7:0];
                        o_byte_valid <= 1'b1;
                        shift        <= head_ext >> 8;
                        byte_idx     <= '0;
                    end
                end
                TByte: begin
                    if (i_byte_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            o_byte       <= '0;
                            o_byte_valid <= 1'b0;
                            tx_word_cnt  <= tx_word_cnt + CW'(1);
                            if (frame_end) begin
                                frame_done <= 1'b1;
                                restart    <= continuous;
                                tx_state   <= TIdle;
                            end else begin
                                tx_state <= TWaitW;
                            end
                        end else begin
                            o_byte   <= shift[7:0];
                            shift    <= shift >> 8;
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                end
                default: tx_state <= TIdle;
            endcase
        end
    end

    assign busy = (cap_state != CIdle) || (tx_state != TIdle);

endmodule
